// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the RX frame controller and its environment
// (serial line, configuration, edge/bit counter, received-word outputs).
// master: the frame controller.  slave: line driver / counter / consumer side.
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  rx_in;
    logic [PRESC_W-1:0]    prescale;
    logic                  par_en;
    logic                  par_typ;
    logic [3:0]            bit_cnt;
    logic [PRESC_W-1:0]    edge_cnt;
    logic                  cnt_enable;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        input  rx_in, prescale, par_en, par_typ, bit_cnt, edge_cnt,
        output cnt_enable, cnt_clr, data_out, data_valid, par_err, stp_err
    );

    modport slave (
        output rx_in, prescale, par_en, par_typ, bit_cnt, edge_cnt,
        input  cnt_enable, cnt_clr, data_out, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// rx_majority_sampler: captures rx_in at three edges around mid-bit and
// votes. The vote is stable from edge_cnt = mid+2 until the next bit's captures.
module rx_majority_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sampled_bit
);
    logic [PRESC_W-1:0] mid;
    logic [2:0]         smp_q;

    assign mid = prescale >> 1;

    // Capture the line at mid-1, mid and mid+1 of the current bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= 3'b111;
        end else begin
            if (edge_cnt == mid - PRESC_W'(1)) smp_q[0] <= rx_in;
            if (edge_cnt == mid)               smp_q[1] <= rx_in;
            if (edge_cnt == mid + PRESC_W'(1)) smp_q[2] <= rx_in;
        end
    end

    assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: steers an external edge/bit counter, deserialises
// LSB-first data from majority-voted mid-bit samples and checks start, parity
// and stop bits.
// Optional feature macro: UART_RX_PARITY_EN (parity bit support and par_err).
//
// state  | meaning
// IDLE   | line idle, counter held clear; falling edge starts a frame
// START  | qualifying the start bit; a high sample is a glitch
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | checking the parity bit (only with parity support built in)
// STOP   | checking the stop bit and publishing the word
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_frame_ctrl_if.master  bus
);
    rx_state_e             state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  stp_err_q;
    logic                  cnt_enable_q;
    logic                  cnt_clr_q;
    logic                  sampled_bit;
    logic                  bit_end;
    logic                  par_active;
    logic                  par_err_now;

    assign bit_end = (bus.edge_cnt == bus.prescale - PRESC_W'(1));

    rx_majority_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (bus.rx_in),
        .edge_cnt    (bus.edge_cnt),
        .prescale    (bus.prescale),
        .sampled_bit (sampled_bit)
    );

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_typ_q;
    logic par_err_q;
    logic exp_par;

    assign par_active  = par_en_q;
    assign par_err_now = par_err_q;
    assign exp_par     = (^shift_q) ^ (par_typ_q == PAR_ODD);
`else
    // Parity configuration pins stay on the port list but are not used.
    logic unused_par_cfg;

    assign unused_par_cfg = bus.par_en ^ bus.par_typ;
    assign par_active     = 1'b0;
    assign par_err_now    = 1'b0;
`endif

    // Frame FSM with registered counter controls, shift register and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            stp_err_q    <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_clr_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_err_q    <= 1'b0;
`endif
        end else begin
            data_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!bus.rx_in) begin
                        state        <= ST_START;
                        cnt_clr_q    <= 1'b0;
                        cnt_enable_q <= 1'b1;
                        stp_err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_en_q     <= bus.par_en;
                        par_typ_q    <= bus.par_typ;
                        par_err_q    <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        if (sampled_bit) begin
                            state        <= ST_IDLE;
                            cnt_clr_q    <= 1'b1;
                            cnt_enable_q <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        if (bus.bit_cnt == 4'(DATA_WIDTH)) begin
                            state <= par_active ? ST_PARITY : ST_STOP;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        if (sampled_bit != exp_par) par_err_q <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        stp_err_q    <= ~sampled_bit;
                        state        <= ST_IDLE;
                        cnt_clr_q    <= 1'b1;
                        cnt_enable_q <= 1'b0;
                        if (sampled_bit && !par_err_now) begin
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    cnt_clr_q    <= 1'b1;
                    cnt_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.cnt_enable = cnt_enable_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.par_err    = par_err_now;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: models the edge/bit counter, drives serial
// frames and checks each frame end against a queue of expected results.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
    import uart_rx_pkg::*;

    typedef struct {
        bit         exp_valid;
        logic [7:0] data;
        bit         pe;
        bit         se;
        int         exp_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_clr;
    bit   pulse_chk;
    logic [7:0] last_good;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESC_W(6)) ifc ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge/bit counter model: clear has priority over enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifc.edge_cnt <= '0;
            ifc.bit_cnt  <= '0;
        end else if (ifc.cnt_clr) begin
            ifc.edge_cnt <= '0;
            ifc.bit_cnt  <= '0;
        end else if (ifc.cnt_enable) begin
            if (ifc.edge_cnt == ifc.prescale - 6'd1) begin
                ifc.edge_cnt <= '0;
                ifc.bit_cnt  <= ifc.bit_cnt + 4'd1;
            end else begin
                ifc.edge_cnt <= ifc.edge_cnt + 6'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each return to IDLE (cnt_clr rising) closes one expected frame.
    always @(negedge clk) begin
        if (ifc.cnt_clr === 1'b1 && prev_clr === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_end at cycle %0d", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_valid", {31'd0, ifc.data_valid}, {31'd0, mon_e.exp_valid});
                check("data_out",   {24'd0, ifc.data_out},   {24'd0, mon_e.data});
                check("par_err",    {31'd0, ifc.par_err},    {31'd0, mon_e.pe});
                check("stp_err",    {31'd0, ifc.stp_err},    {31'd0, mon_e.se});
                check("cnt_enable", {31'd0, ifc.cnt_enable}, 32'd0);
                if (mon_e.exp_cyc >= 0) check("latency", 32'(cyc), 32'(mon_e.exp_cyc));
                pulse_chk = mon_e.exp_valid;
            end
        end else if (pulse_chk) begin
            check("valid_width", {31'd0, ifc.data_valid}, 32'd0);
            pulse_chk = 1'b0;
        end else if (ifc.data_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spurious_valid at cycle %0d data 0x%0h", cyc, ifc.data_out);
        end
        prev_clr = ifc.cnt_clr;
    end

    task automatic drive_bit(input logic b, input int p);
        ifc.rx_in = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit with_par,
                              input logic par_bit, input logic stop_bit,
                              input bit exp_valid, input logic [7:0] exp_data,
                              input bit exp_pe, input bit exp_se, input bit chk_lat);
        exp_t e;
        int nb;
        nb = with_par ? 11 : 10;
        ifc.prescale = 6'(p);
        e.exp_valid = exp_valid;
        e.data      = exp_data;
        e.pe        = exp_pe;
        e.se        = exp_se;
        e.exp_cyc   = chk_lat ? cyc + 1 + nb * p : -1;
        exp_q.push_back(e);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (with_par) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        ifc.rx_in = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ifc.cnt_clr !== 1'b1) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d frames still pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        prev_clr  = 1'b1;
        pulse_chk = 1'b0;
        last_good = 8'h00;
        rst_n        = 1'b0;
        ifc.rx_in    = 1'b1;
        ifc.prescale = 6'(PRESCALE_8);
        ifc.par_en   = 1'b0;
        ifc.par_typ  = PAR_EVEN;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data_out",   {24'd0, ifc.data_out},   32'd0);
        check("rst_data_valid", {31'd0, ifc.data_valid}, 32'd0);
        check("rst_par_err",    {31'd0, ifc.par_err},    32'd0);
        check("rst_stp_err",    {31'd0, ifc.stp_err},    32'd0);
        check("rst_cnt_enable", {31'd0, ifc.cnt_enable}, 32'd0);
        check("rst_cnt_clr",    {31'd0, ifc.cnt_clr},    32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // 1: prescale 8, no parity, 0xA5
        send_frame(8'hA5, PRESCALE_8, 0, 1'b0, 1'b1, 1, 8'hA5, 0, 0, 1);
        last_good = 8'hA5;
        wait_done("t1_a5");

`ifdef UART_RX_PARITY_EN
        // 2: prescale 16, even parity, 0x3C with wrong parity bit 1
        ifc.par_en  = 1'b1;
        ifc.par_typ = PAR_EVEN;
        send_frame(8'h3C, PRESCALE_16, 1, 1'b1, 1'b1, 0, last_good, 1, 0, 1);
        wait_done("t2_par_bad");
        // odd parity, 0x07 has three ones, so correct parity bit is 0
        ifc.par_typ = PAR_ODD;
        send_frame(8'h07, PRESCALE_16, 1, 1'b0, 1'b1, 1, 8'h07, 0, 0, 1);
        last_good = 8'h07;
        wait_done("t2_par_odd_ok");
`else
        // 2 without parity support: par_en ignored, no parity bit on the line
        ifc.par_en  = 1'b1;
        ifc.par_typ = PAR_EVEN;
        send_frame(8'h3C, PRESCALE_16, 0, 1'b0, 1'b1, 1, 8'h3C, 0, 0, 1);
        last_good = 8'h3C;
        wait_done("t2_no_parity");
`endif
        ifc.par_en  = 1'b0;
        ifc.par_typ = PAR_EVEN;

        // 3: prescale 32, 0x81 with stop bit 0
        send_frame(8'h81, PRESCALE_32, 0, 1'b0, 1'b0, 0, last_good, 0, 1, 1);
        wait_done("t3_stop_err");
        check("t3_idle_cnt_clr", {31'd0, ifc.cnt_clr}, 32'd1);

        // 4: 3-clock glitch at prescale 16; also clears the earlier stp_err
        ifc.prescale = 6'(PRESCALE_16);
        e.exp_valid = 0; e.data = last_good; e.pe = 0; e.se = 0;
        e.exp_cyc   = cyc + 1 + PRESCALE_16;
        exp_q.push_back(e);
        ifc.rx_in = 1'b0;
        repeat (3) @(posedge clk); #1;
        ifc.rx_in = 1'b1;
        wait_done("t4_glitch");
        check("t4_cnt_clr", {31'd0, ifc.cnt_clr}, 32'd1);

        // 5: back-to-back 0x11 then 0xEE with no idle gap
        send_frame(8'h11, PRESCALE_16, 0, 1'b0, 1'b1, 1, 8'h11, 0, 0, 1);
        send_frame(8'hEE, PRESCALE_16, 0, 1'b0, 1'b1, 1, 8'hEE, 0, 0, 0);
        wait_done("t5_b2b");

        // 6: reset in the middle of the data bits, then a clean 0x5A
        ifc.prescale = 6'(PRESCALE_8);
        e.exp_valid = 0; e.data = 8'h00; e.pe = 0; e.se = 0; e.exp_cyc = -1;
        exp_q.push_back(e);
        drive_bit(1'b0, PRESCALE_8);
        drive_bit(1'b0, PRESCALE_8);
        drive_bit(1'b1, PRESCALE_8);
        ifc.rx_in = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_data_out",   {24'd0, ifc.data_out},   32'd0);
        check("t6_rst_cnt_clr",    {31'd0, ifc.cnt_clr},    32'd1);
        check("t6_rst_cnt_enable", {31'd0, ifc.cnt_enable}, 32'd0);
        @(posedge clk); #1;
        ifc.rx_in = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        send_frame(8'h5A, PRESCALE_8, 0, 1'b0, 1'b1, 1, 8'h5A, 0, 0, 1);
        wait_done("t6_5a");

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
